usb_system_cpu_oci_trace_capture: RTL and testbench
===================================================

// Module: usb_system_cpu_oci_trace_capture
// PURPOSE
//  Parametrised successor to the CPU OCI test-bench monitor. It captures debug-trace
//  (DCT) words presented by the OCI and stores them in a circular buffer.
//  It tallies trace entries and freezes on the end-of-test handshake. The buffer can
//  be drained through a read port by the bench or by a JTAG-side reader.
//  Sits beside the CPU OCI block in the usb_system simulation/debug hierarchy.
// PARAMETERS
//  DCT_W      30  width of dct_buffer (one trace word)
//  CNT_W       4  width of dct_count (entries packed in the word)
//  DEPTH      16  buffer depth in words; power of two, >=2; AW=$clog2(DEPTH)
//  WRAP_MODE   0  0 = when full, drop the new word and set overflow;
//                 1 = when full, overwrite the oldest word and set overflow
//  TOT_W      16  width of total_count accumulator
// PORTS
//  clk            in   1        sole clock, all logic on rising edge
//  reset_n        in   1        synchronous, active-low reset
//  dct_valid      in   1        dct_buffer/dct_count valid this cycle
//  dct_buffer     in   DCT_W    trace word
//  dct_count      in   CNT_W    number of entries in word (0 = none)
//  test_ending    in   1        pulse/level: bench requests capture stop
//  test_has_ended in   1        level: test finished, freeze buffer
//  rd_req         in   1        pop one word (ignored when empty)
//  rd_data        out  DCT_W+CNT_W {dct_count,dct_buffer} of popped word
//  rd_valid       out  1        rd_data valid (1-cycle pulse)
//  level          out  AW+1     words currently stored, 0..DEPTH
//  overflow       out  1        sticky: word dropped or overwritten
//  total_count    out  TOT_W    saturating sum of dct_count over captured words
//  state          out  2        0 RUN, 1 ENDING, 2 FROZEN
//  done           out  1        1 in FROZEN with level==0
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): pointers=0, level=0, overflow=0, total_count=0,
//    rd_data=0, rd_valid=0, state=RUN, done=0. Reset mid-capture discards all contents.
//  - Capture occurs when dct_valid=1 and state is RUN. It writes {dct_count,dct_buffer}
//    at wr_ptr and increments wr_ptr mod DEPTH. Level is visible on the next cycle.
//  - Words with dct_count==0 are still stored. They add 0 to total_count.
//  - total_count += dct_count on each accepted word. It saturates at 2^TOT_W-1 and
//    never wraps.
//  - Full (level==DEPTH) with a capture request:
//      WRAP_MODE=0: the word is dropped, overflow<=1, and total_count is unchanged.
//      WRAP_MODE=1: the word is written, rd_ptr advances, level stays DEPTH,
//      overflow<=1, and total_count is updated.
//  - Read: when rd_req=1 and level>0, rd_data <= mem[rd_ptr] and rd_valid=1 on the
//    next cycle (latency 1). rd_ptr advances mod DEPTH. rd_req when empty gives
//    rd_valid=0, and rd_data holds its last value.
//  - Simultaneous capture and read:
//      Not full: level is unchanged and both pointers advance.
//      Full, WRAP_MODE=1: the read takes the oldest word, the new word is written,
//      and overflow is NOT set.
//      Empty: the read is ignored and the write proceeds (no bypass).
//  - FSM:
//      RUN -> ENDING when test_ending=1.
//      RUN or ENDING -> FROZEN when test_has_ended=1 (this has priority over
//      test_ending).
//      ENDING -> FROZEN on the cycle after entry, unconditionally.
//      FROZEN is left only by reset.
//    Capture is enabled only in RUN. The word presented in the same cycle that
//    test_ending rises IS captured, because the FSM is still in RUN. The word
//    presented with test_has_ended is also captured if the FSM is in RUN.
//    Reads are allowed in all states.
//  - done = (state==FROZEN) && (level==0). It is registered-consistent with level.
//  - All outputs are registered. There is no combinational path from input to output.
// TESTING
//  1. Reset, then 5 valid words with dct_count=1..5 and no reads -> level=5,
//     total_count=15, overflow=0, state=RUN.
//  2. DEPTH=16, WRAP_MODE=0, 20 writes of data i=0..19 -> level=16, overflow=1;
//     16 reads return 0..15, each 1 cycle after rd_req.
//  3. DEPTH=16, WRAP_MODE=1, 20 writes of i=0..19 -> level=16, overflow=1;
//     reads return 4..19.
//  4. Write word A together with test_ending -> A captured; the word on the next
//     cycle is not; state goes 1 then 2; draining the buffer gives done=1.
//  5. Full buffer with simultaneous write+read, WRAP_MODE=1 -> oldest word
//     returned, level=16, overflow stays 0.
//  6. total_count at 0xFFFE, write dct_count=5 -> 0xFFFF; reset_n=0 for 1 cycle
//     mid-stream -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/usb_system_cpu_oci_trace_capture.sv
// usb_system_cpu_oci_trace_capture
// Captures OCI debug-trace words into a circular buffer, keeps a saturating tally of
// trace entries and freezes capture once the end-of-test handshake completes.
// The buffer can be drained through a one-word-per-request read port at any time.
module usb_system_cpu_oci_trace_capture #(
    parameter int DCT_W     = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0,
    parameter int TOT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      dct_valid,
    input  logic [DCT_W-1:0]          dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      rd_req,
    output logic [DCT_W+CNT_W-1:0]    rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [TOT_W-1:0]          total_count,
    output logic [1:0]                state,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = DCT_W + CNT_W;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENDING = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_d;
    logic            is_full;
    logic            is_empty;
    logic            capture;
    logic            do_read;
    logic            accept;
    logic            overwrite;
    logic            drop;
    logic            grows;
    logic [TOT_W:0]  total_sum;

    // Decide what happens to the buffer this cycle: capture, read, overwrite or drop.
    always_comb begin
        is_full   = (level == (AW+1)'(DEPTH));
        is_empty  = (level == '0);
        capture   = dct_valid && (state_q == ST_RUN);
        do_read   = rd_req && !is_empty;
        accept    = capture && (!is_full || (WRAP_MODE != 0));
        overwrite = accept && is_full && !do_read;
        drop      = capture && !accept;
        grows     = accept && (!is_full || do_read);
        total_sum = {1'b0, total_count} + (TOT_W+1)'(dct_count);
        level_d   = level;
        if (grows && !do_read) begin
            level_d = level + (AW+1)'(1);
        end else if (!grows && do_read) begin
            level_d = level - (AW+1)'(1);
        end
    end

    // End-of-test handshake: test_has_ended wins over test_ending, ENDING lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (test_has_ended) begin
                    state_d = ST_FROZEN;
                end else if (test_ending) begin
                    state_d = ST_ENDING;
                end
            end
            ST_ENDING: state_d = ST_FROZEN;
            ST_FROZEN: state_d = ST_FROZEN;
            default:   state_d = ST_RUN;
        endcase
    end

    // State register; only reset leaves FROZEN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage array; contents are meaningless after reset because level returns to zero.
    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            mem[wr_ptr] <= {dct_count, dct_buffer};
        end
    end

    // Pointers, occupancy, read port, sticky overflow, saturating tally and done flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            total_count <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
        end else begin
            rd_valid <= do_read;
            if (do_read) begin
                rd_data <= mem[rd_ptr];
            end
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (total_sum[TOT_W]) begin
                    total_count <= '1;
                end else begin
                    total_count <= total_sum[TOT_W-1:0];
                end
            end
            if (do_read || overwrite) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop || overwrite) begin
                overflow <= 1'b1;
            end
            level <= level_d;
            done  <= (state_d == ST_FROZEN) && (level_d == '0);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_usb_system_cpu_oci_trace_capture.sv
// Bench for usb_system_cpu_oci_trace_capture. Two instances share the same stimulus:
// one drops words when full, the other overwrites the oldest word. A queue-based model
// per instance predicts the buffer, and words expected on the read port are pushed to a
// scoreboard queue when the read is requested and popped when rd_valid appears.
module tb_usb_system_cpu_oci_trace_capture;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int DEPTH = 16;
    localparam int TOT_W = 16;
    localparam int W     = DCT_W + CNT_W;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             dct_valid = 1'b0;
    logic [DCT_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0] dct_count = '0;
    logic             test_ending = 1'b0;
    logic             test_has_ended = 1'b0;
    logic             rd_req = 1'b0;

    logic [W-1:0]     rd_data_o   [2];
    logic             rd_valid_o  [2];
    logic [AW:0]      level_o     [2];
    logic             overflow_o  [2];
    logic [TOT_W-1:0] total_o     [2];
    logic [1:0]       state_o     [2];
    logic             done_o      [2];

    logic [W-1:0]     mq [2][$];
    logic [W-1:0]     sb [2][$];
    logic             m_ovf   [2];
    int               m_total [2];
    int               m_state [2];

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    usb_system_cpu_oci_trace_capture #(
        .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(0), .TOT_W(TOT_W)
    ) u_drop (
        .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_req(rd_req), .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
        .level(level_o[0]), .overflow(overflow_o[0]), .total_count(total_o[0]),
        .state(state_o[0]), .done(done_o[0])
    );

    usb_system_cpu_oci_trace_capture #(
        .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(1), .TOT_W(TOT_W)
    ) u_wrap (
        .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_req(rd_req), .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
        .level(level_o[1]), .overflow(overflow_o[1]), .total_count(total_o[1]),
        .state(state_o[1]), .done(done_o[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks_total++;
        if (got === want) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then compare the read port.
    task automatic applyStimulus(input logic valid, input logic [CNT_W-1:0] cnt,
                                 input logic [DCT_W-1:0] data, input logic ending,
                                 input logic ended, input logic rd);
        bit   full;
        bit   cap;
        bit   rd_ok;
        logic exp_rv [2];
        dct_valid      = valid;
        dct_count      = cnt;
        dct_buffer     = data;
        test_ending    = ending;
        test_has_ended = ended;
        rd_req         = rd;
        for (int m = 0; m < 2; m++) begin
            exp_rv[m] = 1'b0;
            if (!reset_n) begin
                mq[m].delete();
                sb[m].delete();
                m_ovf[m]   = 1'b0;
                m_total[m] = 0;
                m_state[m] = 0;
            end else begin
                full  = (mq[m].size() == DEPTH);
                cap   = valid && (m_state[m] == 0);
                rd_ok = rd && (mq[m].size() > 0);
                if (rd_ok) begin
                    sb[m].push_back(mq[m].pop_front());
                    exp_rv[m] = 1'b1;
                end
                if (cap) begin
                    if (!full || m == 1) begin
                        if (full && !rd_ok) begin
                            void'(mq[m].pop_front());
                            m_ovf[m] = 1'b1;
                        end
                        mq[m].push_back({cnt, data});
                        m_total[m] = m_total[m] + int'(cnt);
                        if (m_total[m] > 65535) m_total[m] = 65535;
                    end else begin
                        m_ovf[m] = 1'b1;
                    end
                end
                if (m_state[m] == 0) begin
                    if (ended) m_state[m] = 2;
                    else if (ending) m_state[m] = 1;
                end else if (m_state[m] == 1) begin
                    m_state[m] = 2;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("rd_valid_m%0d", m), 64'(rd_valid_o[m]), 64'(exp_rv[m]));
            if (rd_valid_o[m] && sb[m].size() > 0) begin
                checkOutput($sformatf("rd_data_m%0d", m), 64'(rd_data_o[m]), 64'(sb[m].pop_front()));
            end
        end
    endtask

    task automatic checkState(input string tag);
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("%s_m%0d_level", tag, m), 64'(level_o[m]), 64'(mq[m].size()));
            checkOutput($sformatf("%s_m%0d_ovf", tag, m), 64'(overflow_o[m]), 64'(m_ovf[m]));
            checkOutput($sformatf("%s_m%0d_total", tag, m), 64'(total_o[m]), 64'(m_total[m]));
            checkOutput($sformatf("%s_m%0d_state", tag, m), 64'(state_o[m]), 64'(m_state[m]));
            checkOutput($sformatf("%s_m%0d_done", tag, m), 64'(done_o[m]),
                        64'((m_state[m] == 2) && (mq[m].size() == 0)));
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset values
        reset_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        doReset();
        checkState("reset");
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("reset_m%0d_rd_data", m), 64'(rd_data_o[m]), 64'(0));
        end

        // Five words with counts 1..5, no reads
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, CNT_W'(i), DCT_W'(32'h100 + i), 1'b0, 1'b0, 1'b0);
        end
        checkState("t1");
        checkOutput("t1_level_abs", 64'(level_o[0]), 64'(5));
        checkOutput("t1_total_abs", 64'(total_o[0]), 64'(15));

        // Twenty writes into a 16-deep buffer, then drain
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, CNT_W'(1), DCT_W'(i), 1'b0, 1'b0, 1'b0);
        end
        checkState("t2_full");
        checkOutput("t2_drop_level_abs", 64'(level_o[0]), 64'(16));
        checkOutput("t3_wrap_ovf_abs", 64'(overflow_o[1]), 64'(1));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_first_read_abs", 64'(rd_data_o[0]), 64'({4'd1, 30'd0}));
        checkOutput("t3_first_read_abs", 64'(rd_data_o[1]), 64'({4'd1, 30'd4}));
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkState("t2_drained");
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("t2_sb_m%0d_left", m), 64'(sb[m].size()), 64'(0));
        end

        // Full buffer with simultaneous write and read
        doReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, CNT_W'(2), DCT_W'(32'h200 + i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, CNT_W'(3), DCT_W'(32'h2AA), 1'b0, 1'b0, 1'b1);
        checkState("t5");
        checkOutput("t5_wrap_ovf_abs", 64'(overflow_o[1]), 64'(0));
        checkOutput("t5_wrap_level_abs", 64'(level_o[1]), 64'(16));

        // Word with test_ending is captured, the next one is not, then drain to done
        doReset();
        applyStimulus(1'b1, CNT_W'(1), DCT_W'(32'h300), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, CNT_W'(2), DCT_W'(32'hA), 1'b1, 1'b0, 1'b0);
        checkState("t4_ending");
        checkOutput("t4_state_abs", 64'(state_o[0]), 64'(1));
        applyStimulus(1'b1, CNT_W'(7), DCT_W'(32'hB), 1'b0, 1'b0, 1'b0);
        checkState("t4_frozen");
        checkOutput("t4_level_abs", 64'(level_o[1]), 64'(2));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_done_early", 64'(done_o[0]), 64'(0));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        checkState("t4_drained");
        checkOutput("t4_done_abs", 64'(done_o[1]), 64'(1));

        // test_has_ended takes priority over test_ending; its word is still captured
        doReset();
        applyStimulus(1'b1, CNT_W'(4), DCT_W'(32'h400), 1'b1, 1'b1, 1'b0);
        checkState("t7");
        checkOutput("t7_state_abs", 64'(state_o[0]), 64'(2));

        // Saturating tally with a steady read stream, then reset mid-stream
        doReset();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4368; i++) begin
            applyStimulus(1'b1, CNT_W'(15), DCT_W'(i), 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, CNT_W'(14), DCT_W'(32'h500), 1'b0, 1'b0, 1'b1);
        checkState("t6_fffe");
        checkOutput("t6_fffe_abs", 64'(total_o[0]), 64'(16'hFFFE));
        applyStimulus(1'b1, CNT_W'(5), DCT_W'(32'h501), 1'b0, 1'b0, 1'b1);
        checkOutput("t6_sat_abs", 64'(total_o[1]), 64'(16'hFFFF));
        applyStimulus(1'b1, CNT_W'(3), DCT_W'(32'h502), 1'b0, 1'b0, 1'b0);
        checkState("t6_sat");
        reset_n = 1'b0;
        applyStimulus(1'b1, CNT_W'(6), DCT_W'(32'h503), 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        checkState("t6_reset");
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("t6_reset_m%0d_rd_data", m), 64'(rd_data_o[m]), 64'(0));
            checkOutput($sformatf("t6_reset_m%0d_total", m), 64'(total_o[m]), 64'(0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
